// File: rtl/full_adder_2bit.sv
// Registered ripple-carry adder: WIDTH full-adder cells feeding one output
// register stage. Produces sum, carry-out and a two's-complement overflow flag.

// Single-bit full-adder cell; one instance per operand bit.
module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ c;
   assign co = (a & b) | (a & c) | (b & c);
endmodule

module full_adder_2bit #(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             out_valid
);

   // carry chain: c[0] is the carry-in, c[WIDTH] the carry-out
   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] s;
   logic             ovf_c;

   assign c[0] = cin;

   full_adder_cell u_cell [WIDTH-1:0] (
      .a  (a),
      .b  (b),
      .c  (c[WIDTH-1:0]),
      .s  (s),
      .co (c[WIDTH:1])
   );

   // signed overflow: carry into the MSB differs from carry out of it
   // (for WIDTH=1 the carry into the MSB is cin itself)
   assign ovf_c = c[WIDTH] ^ c[WIDTH-1];

   // capture on valid; results hold while idle so X on idle inputs never lands
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum       <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            sum  <= s;
            cout <= c[WIDTH];
            ovf  <= ovf_c;
         end
      end
   end

endmodule

// File: tb/tb_full_adder_2bit.sv
// Scoreboard bench for full_adder_2bit at WIDTH=2, 8 and 1. Expected results
// come from an arithmetic model (a+b+cin, sign-rule overflow), queued on drive.
module tb_full_adder_2bit;

   typedef struct packed {
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
   } exp_t;

   logic       clk;
   logic       rst_n;

   logic       iv2, cin2, cout2, ovf2, ov2;
   logic [1:0] a2, b2, s2;
   logic       iv8, cin8, cout8, ovf8, ov8;
   logic [7:0] a8, b8, s8;
   logic       iv1, cin1, cout1, ovf1, ov1;
   logic [0:0] a1, b1, s1;

   exp_t q2[$], q8[$], q1[$];
   exp_t h2, h8, h1;
   logic have8, have1;

   int n_cmp = 0;
   int n_err = 0;

   full_adder_2bit #(.WIDTH(2)) u_w2 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv2), .a(a2), .b(b2), .cin(cin2),
      .sum(s2), .cout(cout2), .ovf(ovf2), .out_valid(ov2));

   full_adder_2bit #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .a(a8), .b(b8), .cin(cin8),
      .sum(s8), .cout(cout8), .ovf(ovf8), .out_valid(ov8));

   full_adder_2bit #(.WIDTH(1)) u_w1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv1), .a(a1), .b(b1), .cin(cin1),
      .sum(s1), .cout(cout1), .ovf(ovf1), .out_valid(ov1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t model(int w, logic [7:0] a, logic [7:0] b, logic cin);
      exp_t       e;
      logic [8:0] t;
      logic [8:0] mask;
      mask  = (9'd1 << w) - 9'd1;
      t     = {1'b0, a} + {1'b0, b} + {8'd0, cin};
      e.sum = 8'(t & mask);
      e.cout = t[w];
      // same-sign operands whose result sign differs
      e.ovf = (a[w-1] == b[w-1]) && (t[w-1] != a[w-1]);
      return e;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic drive2(logic [1:0] a, logic [1:0] b, logic cin);
      iv2 = 1'b1; a2 = a; b2 = b; cin2 = cin;
      q2.push_back(model(2, {6'd0, a}, {6'd0, b}, cin));
   endtask

   task automatic drive8(logic [7:0] a, logic [7:0] b, logic cin);
      iv8 = 1'b1; a8 = a; b8 = b; cin8 = cin;
      q8.push_back(model(8, a, b, cin));
   endtask

   // one clock edge, then check every DUT against its scoreboard / held value
   task automatic tick(string tag);
      logic e2, e8, e1;
      e2 = iv2; e8 = iv8; e1 = iv1;
      @(posedge clk); #1;
      chk({tag, ".w2.valid"}, 32'(ov2), 32'(e2));
      if (e2) h2 = q2.pop_front();
      chk({tag, ".w2.sum"},  32'(s2),    32'(h2.sum));
      chk({tag, ".w2.cout"}, 32'(cout2), 32'(h2.cout));
      chk({tag, ".w2.ovf"},  32'(ovf2),  32'(h2.ovf));
      chk({tag, ".w8.valid"}, 32'(ov8), 32'(e8));
      if (e8) begin h8 = q8.pop_front(); have8 = 1'b1; end
      if (have8) begin
         chk({tag, ".w8.sum"},  32'(s8),    32'(h8.sum));
         chk({tag, ".w8.cout"}, 32'(cout8), 32'(h8.cout));
         chk({tag, ".w8.ovf"},  32'(ovf8),  32'(h8.ovf));
      end
      chk({tag, ".w1.valid"}, 32'(ov1), 32'(e1));
      if (e1) begin h1 = q1.pop_front(); have1 = 1'b1; end
      if (have1) begin
         chk({tag, ".w1.sum"},  32'(s1),    32'(h1.sum));
         chk({tag, ".w1.cout"}, 32'(cout1), 32'(h1.cout));
         chk({tag, ".w1.ovf"},  32'(ovf1),  32'(h1.ovf));
      end
      iv2 = 1'b0; iv8 = 1'b0; iv1 = 1'b0;
   endtask

   initial begin
      logic [1:0] va [5];
      logic [1:0] vb [5];
      va = '{2'd3, 2'd1, 2'd0, 2'd1, 2'd2};
      vb = '{2'd3, 2'd1, 2'd1, 2'd0, 2'd3};
      h2 = '0; h8 = '0; h1 = '0; have8 = 1'b0; have1 = 1'b0;
      rst_n = 1'b0;
      iv2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
      iv8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
      iv1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;

      // reset state
      #12;
      chk("rst.valid", 32'(ov2), 32'd0);
      chk("rst.sum", 32'(s2), 32'd0);
      chk("rst.cout", 32'(cout2), 32'd0);
      chk("rst.ovf", 32'(ovf2), 32'd0);
      rst_n = 1'b1;
      tick("idle0");

      // load a non-zero result, then reset mid-cycle with a valid operand
      drive2(2'd3, 2'd1, 1'b1);
      tick("pre");
      #2;
      iv2 = 1'b1; a2 = 2'd3; b2 = 2'd3; cin2 = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("arst.valid", 32'(ov2), 32'd0);
      chk("arst.sum", 32'(s2), 32'd0);
      chk("arst.cout", 32'(cout2), 32'd0);
      @(posedge clk); #1;
      chk("arst.edge.valid", 32'(ov2), 32'd0);
      chk("arst.edge.sum", 32'(s2), 32'd0);
      iv2 = 1'b0;
      h2 = '0;
      rst_n = 1'b1;
      tick("rel");
      tick("rel2");

      // cin sweeps, back-to-back
      for (int c = 0; c < 2; c++) begin
         for (int i = 0; i < 5; i++) begin
            drive2(va[i], vb[i], c[0]);
            tick("sweep");
         end
      end

      // hold: one valid then idle with random / unknown operands
      drive2(2'd2, 2'd3, 1'b1);
      tick("hold.v");
      for (int i = 0; i < 3; i++) begin
         a2 = 2'($urandom); b2 = 2'($urandom); cin2 = 1'($urandom);
         if (i == 2) begin a2 = 'x; b2 = 'x; cin2 = 1'bx; end
         tick("hold.i");
      end
      chk("hold.sum", 32'(s2), 32'd2);
      chk("hold.cout", 32'(cout2), 32'd1);

      // exhaustive WIDTH=2
      for (int i = 0; i < 32; i++) begin
         drive2(2'(i >> 3), 2'(i >> 1), i[0]);
         tick("exh");
      end

      // random WIDTH=8 (plus the all-ones corner), then an idle edge
      drive8(8'hff, 8'hff, 1'b1);
      tick("w8c");
      drive8(8'h7f, 8'h00, 1'b1);
      tick("w8c");
      for (int i = 0; i < 24; i++) begin
         drive8(8'($urandom), 8'($urandom), 1'($urandom));
         tick("w8r");
      end
      tick("w8idle");

      // WIDTH=1
      iv1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
      q1.push_back(model(1, 8'd1, 8'd1, 1'b1));
      tick("w1");
      chk("w1.sum", 32'(s1), 32'd1);
      chk("w1.cout", 32'(cout1), 32'd1);
      chk("w1.ovf", 32'(ovf1), 32'd0);
      tick("w1idle");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/full_adder_2bit.md
Name: full_adder_2bit

Overview:
- Registered multi-bit ripple-carry adder; default width 2 bits.
- Adds two unsigned operands and a carry-in, producing a sum, a carry-out and a signed-overflow flag.
- Built from per-bit full-adder cells, with a single output register stage.
- Used as a small arithmetic leaf block in datapaths driven by one clock domain.

Parameters:
- WIDTH, 2, operand and sum width in bits; legal range is 1 to 32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands on a, b and cin are valid this cycle
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- cin  input  1  carry-in
- sum  output  WIDTH  registered result bits [WIDTH-1:0]
- cout  output  1  registered carry-out (result bit WIDTH)
- ovf  output  1  registered two's-complement overflow flag
- out_valid  output  1  sum, cout and ovf hold a new result

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset: while rst_n=0, sum=0, cout=0, ovf=0 and out_valid=0, immediately and independent of clk.
- Reset release: the first capture happens on the first rising clk edge with rst_n=1.
- Combinational core: WIDTH chained full-adder cells.
  - Cell i computes s[i] = a[i]^b[i]^c[i] and c[i+1] = majority(a[i], b[i], c[i]), with c[0]=cin.
  - Result: {c[WIDTH], s} = a + b + cin, exact with no truncation.
  - Maximum value is 2^(WIDTH+1)-1, which is 7 for WIDTH=2.
- Overflow: ovf = c[WIDTH] XOR c[WIDTH-1], computed as signed overflow of the sum.
  - For WIDTH=1, ovf = c[1] XOR cin.
- Capture: on a rising clk edge with in_valid=1, sum, cout and ovf load the core outputs and out_valid<=1.
- Latency: exactly 1 cycle from an in_valid sample to the matching out_valid.
- Throughput: one result per cycle. Back-to-back valid inputs produce back-to-back results, with no bubbles.
- Idle: on a rising edge with in_valid=0, out_valid<=0 and sum, cout and ovf hold their previous values.
  - Outputs are never cleared except by reset.
- No backpressure: results are not stalled and must be consumed in the cycle out_valid=1.
- Reset mid-operation: an operand sampled in the cycle reset asserts is discarded. No stale out_valid appears after release.
- X on a, b or cin while in_valid=0 must not propagate to the outputs.
- Wrap-around: the sum register holds the low WIDTH bits and the carry goes to cout.
  - Example: 3+3+0 gives sum=2, cout=1.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with in_valid=1, a=3, b=3 -> all outputs 0 immediately. After release with in_valid=0, out_valid stays 0.
- Cin=0 sweep, back-to-back with in_valid=1, each result 1 cycle later with out_valid=1:
  - (3,3) -> sum=2, cout=1, ovf=0
  - (1,1) -> sum=2, cout=0, ovf=1
  - (0,1) -> sum=1, cout=0, ovf=0
  - (1,0) -> sum=1, cout=0, ovf=0
  - (2,3) -> sum=1, cout=1, ovf=1
- Cin=1 sweep:
  - (3,3) -> sum=3, cout=1, ovf=0
  - (1,1) -> sum=3, cout=0, ovf=1
  - (0,1) -> sum=2, cout=0, ovf=1
  - (1,0) -> sum=2, cout=0, ovf=1
  - (2,3) -> sum=2, cout=1, ovf=0
- Hold: a valid (2,3,cin=1) then 3 idle cycles with random a/b -> sum=2 and cout=1 held, out_valid high for 1 cycle only.
- Exhaustive: all 32 combinations of a, b, cin at WIDTH=2, plus random vectors at WIDTH=8 -> {cout,sum} == a+b+cin every cycle.
- WIDTH=1: a=1, b=1, cin=1 -> sum=1, cout=1, ovf=0.
